// File: rtl/bin2bcd_seq_seg7_pkg.sv
// Shared definitions for the sequential binary-to-BCD display path.
//   - FSM state encoding
//   - seven-segment code table ({g,f,e,d,c,b,a}, active-high) and blank code
//   - digits_needed(): decimal digits required to show any BIN_W-bit magnitude
package bin2bcd_seq_seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry i is the pattern for digit value i; 10..15 are not BCD and stay dark.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // ceil(w * log10(2)) equals the decimal digit count of 2^w - 1, because
    // a power of two is never a power of ten.
    function automatic int digits_needed(input int w);
        longint unsigned v;
        int              n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                v = v / 64'd10;
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_seg7_if.sv
// Handshake and result bus of bin2bcd_seq_seg7.
//   master: start, is_signed, bin_in (requester)
//   slave : busy, done, neg, ovf, bcd_out, seg_out (converter)
interface bin2bcd_seq_seg7_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic                  is_signed;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic                  neg;
    logic                  ovf;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [7*DIGITS-1:0]   seg_out;

    modport master (
        output start, is_signed, bin_in,
        input  busy, done, neg, ovf, bcd_out, seg_out
    );

    modport slave (
        input  start, is_signed, bin_in,
        output busy, done, neg, ovf, bcd_out, seg_out
    );
endinterface

// File: rtl/bin2bcd_seq_seg7_seg7_digit_dec.sv
// seg7_digit_dec: one BCD digit to a seven-segment pattern.
//   digit_i : 4-bit digit value
//   blank_i : 1 forces the segments dark
//   seg_o   : {g,f,e,d,c,b,a}, active-high
module seg7_digit_dec
    import bin2bcd_seq_seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_TABLE[digit_i];
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/bin2bcd_seq_seg7.sv
// bin2bcd_seq_seg7: iterative shift-add-3 binary to BCD converter with
// seven-segment outputs and optional leading-zero blanking.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of bin2bcd_seq_seg7_if
//                start/is_signed/bin_in in; busy/done/neg/ovf/bcd_out/seg_out out
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; outputs hold the last result
// SHIFT  | one magnitude bit per cycle into the BCD scratch, BIN_W cycles
// DONE   | one cycle, done=1, registered results just updated
module bin2bcd_seq_seg7 #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    parameter int LZB_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bin2bcd_seq_seg7_if.slave     bus
);
    import bin2bcd_seq_seg7_pkg::*;

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    // With enough digits nothing can ever leave the top digit.
    localparam bit OVF_POSSIBLE = (DIGITS < digits_needed(BIN_W));

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic               ovf_scr_q, ovf_scr_d;
    logic               neg_pend_q, neg_pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;

    logic               start_ok;
    logic               neg_in;
    logic               last_shift;
    logic [BCD_W-1:0]   scr_adj;
    logic [BCD_W-1:0]   scr_shift;
    logic               ovf_final;
    logic               busy;
    logic               done;
    logic [DIGITS-1:0]  blank;
    logic               nz_above;
    logic [7*DIGITS-1:0] seg;

    assign start_ok   = (state_q == ST_IDLE) && bus.start;
    assign neg_in     = bus.is_signed && bus.bin_in[BIN_W-1];
    assign last_shift = (cnt_q == CNT_W'(1));

    // Add-3 correction on every digit that would reach 10 or more after the shift.
    always_comb begin
        scr_adj = scr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) begin
                scr_adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
            end
        end
    end

    assign scr_shift = {scr_adj[BCD_W-2:0], mag_q[BIN_W-1]};
    assign ovf_final = OVF_POSSIBLE ? (ovf_scr_q | scr_adj[BCD_W-1]) : 1'b0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok)   state_d = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_d = ST_DONE;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values
    always_comb begin
        mag_d      = mag_q;
        scr_d      = scr_q;
        ovf_scr_d  = ovf_scr_q;
        neg_pend_d = neg_pend_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        if (start_ok) begin
            // Two's-complement negate as unsigned BIN_W bits: the most
            // negative value maps onto its own bit pattern, 2^(BIN_W-1).
            mag_d      = neg_in ? (~bus.bin_in + BIN_W'(1)) : bus.bin_in;
            neg_pend_d = neg_in;
            scr_d      = '0;
            ovf_scr_d  = 1'b0;
            cnt_d      = CNT_W'(BIN_W);
        end else if (state_q == ST_SHIFT) begin
            mag_d     = {mag_q[BIN_W-2:0], 1'b0};
            scr_d     = scr_shift;
            ovf_scr_d = ovf_final;
            cnt_d     = cnt_q - CNT_W'(1);
            if (last_shift) begin
                bcd_d = scr_shift;
                ovf_d = ovf_final;
                neg_d = neg_pend_q && !((scr_shift == '0) && !ovf_final);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q      <= '0;
            scr_q      <= '0;
            ovf_scr_q  <= 1'b0;
            neg_pend_q <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            mag_q      <= mag_d;
            scr_q      <= scr_d;
            ovf_scr_q  <= ovf_scr_d;
            neg_pend_q <= neg_pend_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
        end
    end

    // Digit k>0 goes dark when it and every digit above it are zero.
    always_comb begin
        blank    = '0;
        nz_above = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            nz_above = nz_above | (bcd_q[4*k +: 4] != 4'd0);
            blank[k] = (LZB_EN != 0) && !nz_above;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        seg7_digit_dec u_dec (
            .digit_i (bcd_q[4*k +: 4]),
            .blank_i (blank[k]),
            .seg_o   (seg[7*k +: 7])
        );
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.neg     = neg_q;
    assign bus.ovf     = ovf_q;
    assign bus.bcd_out = bcd_q;
    assign bus.seg_out = seg;

endmodule

// File: tb/tb_bin2bcd_seq_seg7.sv
module tb_bin2bcd_seq_seg7;

    logic clk;
    logic rst_n;

    bin2bcd_seq_seg7_if #(.BIN_W(16), .DIGITS(5)) if5 ();
    bin2bcd_seq_seg7_if #(.BIN_W(16), .DIGITS(4)) if4 ();

    bin2bcd_seq_seg7 #(.BIN_W(16), .DIGITS(5), .LZB_EN(1)) dut5 (
        .clk(clk), .rst_n(rst_n), .bus(if5)
    );
    bin2bcd_seq_seg7 #(.BIN_W(16), .DIGITS(4), .LZB_EN(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [6:0] seg_ref [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        logic [39:0] bcd;
        logic [69:0] seg;
        logic        neg;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] bin;
        logic        sgn;
        logic [19:0] bcd5;
        logic [34:0] seg5;
        logic        neg;
        logic        ovf5;
        logic [15:0] bcd4;
        logic        ovf4;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal arithmetic on the magnitude; blanking from the value being
    // smaller than 10^k.
    function automatic res_t model(input logic [15:0] b, input logic s, input int nd);
        res_t        r;
        longint      mag, p, md;
        int          dg;
        mag = (s && b[15]) ? (65536 - longint'(b)) : longint'(b);
        p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        r.ovf = (mag >= p);
        md    = mag % p;
        r.neg = s && b[15] && (mag != 0);
        r.bcd = '0;
        r.seg = '0;
        p = 1;
        for (int k = 0; k < nd; k++) begin
            dg = int'((md / p) % 10);
            r.bcd[4*k +: 4] = 4'(dg);
            r.seg[7*k +: 7] = (k > 0 && md < p) ? 7'h00 : seg_ref[dg];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic drive(input logic st, input logic [15:0] b, input logic s);
        if5.start = st; if5.bin_in = b; if5.is_signed = s;
        if4.start = st; if4.bin_in = b; if4.is_signed = s;
    endtask

    // Runs one conversion; inputs are scrambled after the start edge to
    // show they are not sampled again. Returns 1 if done was observed.
    task automatic conv(input logic [15:0] b, input logic s, output bit seen);
        int n, busy_n;
        @(negedge clk);
        drive(1'b1, b, s);
        n = 0; busy_n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) drive(1'b0, 16'($urandom), 1'($urandom));
            if (if5.busy) busy_n++;
            if (if5.done) seen = 1;
        end
        check("latency", n, 17);
        check("busy_cycles", busy_n, 16);
        check("done4_with_done5", if4.done, 1'b1);
        if (seen) begin
            @(posedge clk); #1;
            check("done_one_cycle", if5.done, 1'b0);
            check("busy_after_done", if5.busy, 1'b0);
        end
    endtask

    task automatic cmp_model(input logic [15:0] b, input logic s);
        res_t r5, r4;
        r5 = model(b, s, 5);
        r4 = model(b, s, 4);
        check("rnd_bcd5", if5.bcd_out, r5.bcd[19:0]);
        check("rnd_seg5", if5.seg_out, r5.seg[34:0]);
        check("rnd_neg5", if5.neg, r5.neg);
        check("rnd_ovf5", if5.ovf, r5.ovf);
        check("rnd_bcd4", if4.bcd_out, r4.bcd[15:0]);
        check("rnd_seg4", if4.seg_out, r4.seg[27:0]);
        check("rnd_ovf4", if4.ovf, r4.ovf);
    endtask

    initial begin
        bit          seen;
        int          n, done_n;
        res_t        r4;
        logic [15:0] b;
        logic        s;

        vecs[0]  = '{16'd12345, 1'b0, 20'h12345, {7'h06,7'h5B,7'h4F,7'h66,7'h6D}, 1'b0, 1'b0, 16'h2345, 1'b1};
        vecs[1]  = '{16'd0,     1'b0, 20'h00000, {7'h00,7'h00,7'h00,7'h00,7'h3F}, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[2]  = '{16'd907,   1'b0, 20'h00907, {7'h00,7'h00,7'h6F,7'h3F,7'h07}, 1'b0, 1'b0, 16'h0907, 1'b0};
        vecs[3]  = '{16'h8000,  1'b1, 20'h32768, {7'h4F,7'h5B,7'h07,7'h7D,7'h7F}, 1'b1, 1'b0, 16'h2768, 1'b1};
        vecs[4]  = '{16'hFFFF,  1'b1, 20'h00001, {7'h00,7'h00,7'h00,7'h00,7'h06}, 1'b1, 1'b0, 16'h0001, 1'b0};
        vecs[5]  = '{16'hFFFF,  1'b0, 20'h65535, {7'h7D,7'h6D,7'h6D,7'h4F,7'h6D}, 1'b0, 1'b0, 16'h5535, 1'b1};
        vecs[6]  = '{16'd9999,  1'b0, 20'h09999, {7'h00,7'h6F,7'h6F,7'h6F,7'h6F}, 1'b0, 1'b0, 16'h9999, 1'b0};
        vecs[7]  = '{16'h8000,  1'b0, 20'h32768, {7'h4F,7'h5B,7'h07,7'h7D,7'h7F}, 1'b0, 1'b0, 16'h2768, 1'b1};
        vecs[8]  = '{16'h7FFF,  1'b1, 20'h32767, {7'h4F,7'h5B,7'h07,7'h7D,7'h07}, 1'b0, 1'b0, 16'h2767, 1'b1};
        vecs[9]  = '{16'd0,     1'b1, 20'h00000, {7'h00,7'h00,7'h00,7'h00,7'h3F}, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[10] = '{16'hFFF6,  1'b1, 20'h00010, {7'h00,7'h00,7'h00,7'h06,7'h3F}, 1'b1, 1'b0, 16'h0010, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 16'd0, 1'b0);
        #23;
        check("rst_busy", if5.busy, 1'b0);
        check("rst_done", if5.done, 1'b0);
        check("rst_neg",  if5.neg,  1'b0);
        check("rst_ovf",  if5.ovf,  1'b0);
        check("rst_bcd",  if5.bcd_out, 20'h0);
        check("rst_seg",  if5.seg_out, {7'h00,7'h00,7'h00,7'h00,7'h3F});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            conv(vecs[i].bin, vecs[i].sgn, seen);
            // conv leaves us one cycle past done; results must still hold.
            r4 = model(vecs[i].bin, vecs[i].sgn, 4);
            check($sformatf("vec%0d_bcd5", i), if5.bcd_out, vecs[i].bcd5);
            check($sformatf("vec%0d_seg5", i), if5.seg_out, vecs[i].seg5);
            check($sformatf("vec%0d_neg5", i), if5.neg, vecs[i].neg);
            check($sformatf("vec%0d_ovf5", i), if5.ovf, vecs[i].ovf5);
            check($sformatf("vec%0d_bcd4", i), if4.bcd_out, vecs[i].bcd4);
            check($sformatf("vec%0d_ovf4", i), if4.ovf, vecs[i].ovf4);
            check($sformatf("vec%0d_neg4", i), if4.neg, vecs[i].neg);
            check($sformatf("vec%0d_seg4", i), if4.seg_out, r4.seg[27:0]);
        end

        // Starts during SHIFT (edge 5) and during DONE (edge 17) are ignored;
        // the one held into edge 18 is accepted.
        @(negedge clk);
        drive(1'b1, 16'd4321, 1'b0);
        n = 0; done_n = 0;
        while (n < 19) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) drive(1'b0, 16'd4321, 1'b0);
            if (n == 5) drive(1'b1, 16'd1111, 1'b0);
            if (n == 6) drive(1'b0, 16'd1111, 1'b0);
            if (if5.done) done_n++;
            if (n == 17) begin
                check("ign_done_at_17", if5.done, 1'b1);
                check("ign_result", if5.bcd_out, 20'h04321);
                drive(1'b1, 16'd2222, 1'b0);
            end
            if (n == 18) begin
                check("ign_not_busy_in_idle", if5.busy, 1'b0);
                check("ign_done_dropped", if5.done, 1'b0);
            end
            if (n == 19) begin
                check("accept_after_idle", if5.busy, 1'b1);
                drive(1'b0, 16'd0, 1'b0);
            end
        end
        check("ign_single_done", done_n, 1);
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (if5.done) seen = 1;
        end
        check("accept_latency", n, 16);
        check("accept_result", if5.bcd_out, 20'h02222);

        // Asynchronous reset in the middle of a conversion.
        @(posedge clk); #1;
        conv(16'hFFF6, 1'b1, seen);
        @(negedge clk);
        drive(1'b1, 16'd5555, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 0) drive(1'b0, 16'd5555, 1'b0);
        end
        check("pre_rst_busy", if5.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", if5.busy, 1'b0);
        check("mid_rst_neg",  if5.neg,  1'b0);
        check("mid_rst_ovf",  if5.ovf,  1'b0);
        check("mid_rst_bcd",  if5.bcd_out, 20'h0);
        check("mid_rst_seg",  if5.seg_out, {7'h00,7'h00,7'h00,7'h00,7'h3F});
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (if5.done || if5.busy) done_n++;
        end
        check("mid_rst_no_done", done_n, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (if5.done) done_n++;
        end
        check("post_rst_no_done", done_n, 0);
        conv(16'd100, 1'b0, seen);
        check("post_rst_bcd", if5.bcd_out, 20'h00100);
        check("post_rst_seg", if5.seg_out, {7'h00,7'h00,7'h06,7'h3F,7'h3F});

        // Random conversions against the decimal model.
        for (int i = 0; i < 40; i++) begin
            b = 16'($urandom);
            s = 1'($urandom);
            if (i % 8 == 0) b = 16'($urandom_range(0, 20));
            conv(b, s, seen);
            cmp_model(b, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
